// File: rtl/hazard_forw_ctrl_s.sv
// Hazard detection and operand-forwarding control for a 5-stage RV32I pipeline.
// Tracks EX/MEM/WB destinations and decides ID stalls and bypass selects for the next EX instruction.
module hazard_forw_ctrl_s (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        isForw_ON,
  input  logic        id_valid,
  input  logic [6:0]  id_op,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  output logic [1:0]  forwA,
  output logic [1:0]  forwB,
  output logic        ex_valid,
  output logic        stall,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       isLoad;
  } slot_t;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  slot_t       exSlot_q, memSlot_q, wbSlot_q, exSlot_d;
  logic [1:0]  forwA_q, forwA_d, forwB_q, forwB_d;
  logic [15:0] stallCnt_q, stallCnt_d;
  logic        useRs1, useRs2, idWe, idLoad;
  logic        exHit1, exHit2, memHit1, memHit2;
  logic        unusedWb;

  function automatic logic slotMatch(input slot_t s, input logic [4:0] rs, input logic used);
    return s.valid && s.we && (s.rd != 5'd0) && (s.rd == rs) && used;
  endfunction

  always_comb begin
    useRs1 = 1'b0;
    useRs2 = 1'b0;
    idWe   = 1'b0;
    idLoad = 1'b0;
    case (id_op)
      7'b0110011: begin useRs1 = 1'b1; useRs2 = 1'b1; idWe = 1'b1; end
      7'b0100011,
      7'b1100011: begin useRs1 = 1'b1; useRs2 = 1'b1; end
      7'b0010011,
      7'b1100111: begin useRs1 = 1'b1; idWe = 1'b1; end
      7'b0000011: begin useRs1 = 1'b1; idWe = 1'b1; idLoad = 1'b1; end
      7'b0110111,
      7'b0010111,
      7'b1101111: idWe = 1'b1;
      default:    ;
    endcase
  end

  assign exHit1  = slotMatch(exSlot_q,  id_rs1, useRs1);
  assign exHit2  = slotMatch(exSlot_q,  id_rs2, useRs2);
  assign memHit1 = slotMatch(memSlot_q, id_rs1, useRs1);
  assign memHit2 = slotMatch(memSlot_q, id_rs2, useRs2);

  // With bypassing only a load still in EX is too late; without it any EX/MEM producer blocks.
  assign stall = id_valid && (isForw_ON ? (exSlot_q.isLoad && (exHit1 || exHit2))
                                        : (exHit1 || exHit2 || memHit1 || memHit2));

  always_comb begin
    forwA_d = SEL_RF;
    forwB_d = SEL_RF;
    if (isForw_ON && id_valid && !stall) begin
      if (exHit1)       forwA_d = SEL_EXMEM;
      else if (memHit1) forwA_d = SEL_MEMWB;
      if (exHit2)       forwB_d = SEL_EXMEM;
      else if (memHit2) forwB_d = SEL_MEMWB;
    end
  end

  always_comb begin
    exSlot_d = '0;
    if (!stall) begin
      exSlot_d.valid  = id_valid;
      exSlot_d.rd     = id_rd;
      exSlot_d.we     = idWe;
      exSlot_d.isLoad = idLoad;
    end
  end

  assign stallCnt_d = (stall && (stallCnt_q != 16'hFFFF)) ? stallCnt_q + 16'd1 : stallCnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exSlot_q   <= '0;
      memSlot_q  <= '0;
      wbSlot_q   <= '0;
      forwA_q    <= SEL_RF;
      forwB_q    <= SEL_RF;
      stallCnt_q <= '0;
    end else begin
      exSlot_q   <= exSlot_d;
      memSlot_q  <= exSlot_q;
      wbSlot_q   <= memSlot_q;
      forwA_q    <= forwA_d;
      forwB_q    <= forwB_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  // WB is tracked for completeness; the write-through register file means it never needs a match.
  assign unusedWb = ^wbSlot_q;

  assign forwA       = forwA_q;
  assign forwB       = forwB_q;
  assign ex_valid    = exSlot_q.valid;
  assign stall_count = stallCnt_q;

endmodule
